// File: rtl/xmpl_sram_pkg.sv
// Shared types and helpers for the SRAM controller slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xmpl_sram_pkg;

    typedef enum logic {
        INIT,
        RUN
    } ctrl_state_e;

    // Deepest supported read pipeline; the outstanding counter is sized from it.
    localparam int RD_LAT_MAX = 3;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/xmpl_sram_mem.sv
// Single-port DEPTH x DATA_W storage with per-byte write enables.
// Latency: read data is registered, valid the cycle after en_i with we_i=0.
// Backpressure: none; the caller only enables it for in-range addresses.
module xmpl_sram_mem
    import xmpl_sram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic                   clk_i,
    input  logic                   en_i,
    input  logic                   we_i,
    input  logic [DATA_W/8-1:0]    be_i,
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic [DATA_W-1:0]      wdata_i,
    output logic [DATA_W-1:0]      rdata_o
);

    localparam int BE_W = be_width(DATA_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // One access per cycle: byte-masked write, or a registered read.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/xmpl_sram_ctrl.sv
// Valid/ready SRAM controller with optional zero-fill, read pipeline and response FIFO.
// Latency: read response valid RD_LAT cycles after accept; writes produce no response.
// Backpressure: rsp_ready_i low fills the RD_LAT+1 FIFO; req_ready_o drops once RD_LAT+1 reads are outstanding.
module xmpl_sram_ctrl
    import xmpl_sram_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 12,
    parameter int DEPTH     = 4096,
    parameter int RD_LAT    = 1,
    parameter int INIT_ZERO = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [ADDR_W-1:0]      req_addr_i,
    input  logic [DATA_W/8-1:0]    req_be_i,
    input  logic [DATA_W-1:0]      req_wdata_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [DATA_W-1:0]      rsp_rdata_o,
    output logic                   rsp_err_o,
    output logic                   init_busy_o
);

    localparam int BE_W   = be_width(DATA_W);
    localparam int FIFO_D = RD_LAT + 1;
    localparam int PTR_W  = $clog2(FIFO_D);
    localparam int OUT_W  = $clog2(RD_LAT_MAX + 2);

    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [OUT_W-1:0]  OUT_MAX   = OUT_W'(RD_LAT + 1);
    localparam ctrl_state_e       RST_STATE = (INIT_ZERO != 0) ? INIT : RUN;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] dat;
    } rsp_t;

    // FSM and request-side state
    ctrl_state_e        state_q, state_d;
    logic [ADDR_W-1:0]  init_addr_q, init_addr_d;
    logic               ready_q, ready_d;
    logic [OUT_W-1:0]   outstanding_q, outstanding_d;

    // Read pipeline flags and response FIFO
    logic [RD_LAT-1:0]  vld_q, vld_d;
    logic [RD_LAT-1:0]  err_q, err_d;
    rsp_t               fifo_q [FIFO_D];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     cnt_q, cnt_d;

    logic               rd_acc, wr_acc, in_range;
    logic               mem_en, mem_we;
    logic [BE_W-1:0]    mem_be;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata, mem_rdata;
    logic [DATA_W-1:0]  tail_dat;
    rsp_t               tail_ent, head;
    logic               tail_vld, fifo_empty, rsp_vld, pop, push, fifo_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_range = {1'b0, req_addr_i} < DEPTH_L;
    assign rd_acc   = req_valid_i && ready_q && !req_we_i;
    assign wr_acc   = req_valid_i && ready_q && req_we_i;

    // The single memory port belongs to the zero-fill counter during INIT, else to the request port.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = req_addr_i;
        mem_wdata = req_wdata_i;
        if (state_q == INIT) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_be    = '1;
            mem_addr  = init_addr_q;
            mem_wdata = '0;
        end else begin
            mem_en    = (rd_acc || wr_acc) && in_range;
            mem_we    = req_we_i;
            mem_be    = req_be_i;
        end
    end

    xmpl_sram_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .be_i    (mem_be),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    // Stage 1 data lives in the memory's read register; later stages are plain shift registers.
    if (RD_LAT > 1) begin : g_pipe
        logic [DATA_W-1:0] dat_q [RD_LAT-1];

        // Data shifts every cycle; the valid flags decide which slots carry a response.
        always_ff @(posedge clk_i) begin
            dat_q[0] <= mem_rdata;
            for (int j = 1; j < RD_LAT - 1; j++) begin
                dat_q[j] <= dat_q[j-1];
            end
        end

        assign tail_dat = dat_q[RD_LAT-2];
    end else begin : g_nopipe
        assign tail_dat = mem_rdata;
    end

    assign tail_vld = vld_q[RD_LAT-1];
    assign tail_ent = '{err: err_q[RD_LAT-1], dat: err_q[RD_LAT-1] ? '0 : tail_dat};

    // The pipeline tail bypasses an empty FIFO so the response shows up exactly RD_LAT cycles after accept.
    always_comb begin
        fifo_empty = (cnt_q == '0);
        head       = fifo_empty ? tail_ent : fifo_q[rd_ptr_q];
        rsp_vld    = !fifo_empty || tail_vld;
        pop        = rsp_vld && rsp_ready_i;
        push       = tail_vld && !(fifo_empty && rsp_ready_i);
        fifo_pop   = pop && !fifo_empty;
        cnt_d      = cnt_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, fifo_pop};
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = fifo_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        vld_d[0]   = rd_acc;
        err_d[0]   = rd_acc && !in_range;
        for (int j = 1; j < RD_LAT; j++) begin
            vld_d[j] = vld_q[j-1];
            err_d[j] = err_q[j-1];
        end
        outstanding_d = outstanding_q + {{(OUT_W-1){1'b0}}, rd_acc} - {{(OUT_W-1){1'b0}}, pop};
    end

    // Zero-fill walks 0..DEPTH-1 once, then hands the port to requests; ready is computed from next-state values.
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        if (state_q == INIT) begin
            init_addr_d = init_addr_q + ADDR_W'(1);
            if (init_addr_q == LAST_ADDR) begin
                state_d     = RUN;
                init_addr_d = '0;
            end
        end
        ready_d = (state_d == RUN) && (outstanding_d < OUT_MAX);
    end

    // FSM with its registered ready output.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= RST_STATE;
            init_addr_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            ready_q     <= ready_d;
        end
    end

    // Pipeline flags, FIFO pointers and the outstanding-read counter.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            vld_q         <= '0;
            err_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
            outstanding_q <= '0;
        end else begin
            vld_q         <= vld_d;
            err_q         <= err_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
            outstanding_q <= outstanding_d;
        end
    end

    // FIFO storage: the tail is captured whenever it could not leave directly.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < FIFO_D; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push) begin
            fifo_q[wr_ptr_q] <= tail_ent;
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_vld;
    assign rsp_rdata_o = rsp_vld ? head.dat : '0;
    assign rsp_err_o   = rsp_vld && head.err;
    assign init_busy_o = (state_q == INIT);

endmodule

// File: tb/tb_xmpl_sram_ctrl.sv
// Bench for xmpl_sram_ctrl: scoreboard of expected read responses checked by a separate monitor.
// Main DUT: DEPTH=12, ADDR_W=4, RD_LAT=2, zero-fill on. Second DUT: DEPTH=16, RD_LAT=1.
// Inputs change only on falling edges; the monitor samples 2 ns after the falling edge.
module tb_xmpl_sram_ctrl;

    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int DEP = 12;
    localparam int RL  = 2;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, init_busy;
    logic [AW-1:0] req_addr;
    logic [3:0]    req_be;
    logic [DW-1:0] req_wdata, rsp_rdata;

    logic          b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err, b_init_busy;
    logic [3:0]    b_req_addr;
    logic [3:0]    b_req_be;
    logic [DW-1:0] b_req_wdata, b_rsp_rdata;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_acc = 0;
    exp_t exp_q[$];
    int   pop_edges[$];

    logic [DW-1:0] vec [8] = '{32'h0123_4567, 32'h89AB_CDEF, 32'h1111_2222, 32'h3333_4444,
                               32'h5555_6666, 32'h7777_8888, 32'h9999_AAAA, 32'hBBBB_CCCC};

    xmpl_sram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(RL), .INIT_ZERO(1)) u_dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_be_i(req_be), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .init_busy_o(init_busy)
    );

    xmpl_sram_ctrl #(.DATA_W(DW), .ADDR_W(4), .DEPTH(16), .RD_LAT(1), .INIT_ZERO(1)) u_dut_b (
        .clk_i(clk), .reset_n_i(rst_n),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
        .req_addr_i(b_req_addr), .req_be_i(b_req_be), .req_wdata_i(b_req_wdata),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_rdata_o(b_rsp_rdata),
        .rsp_err_o(b_rsp_err), .init_busy_o(b_init_busy)
    );

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Monitor: every response the DUT hands over is matched against the head of the scoreboard.
    always @(negedge clk) begin
        #2;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_data", rsp_rdata, e.dat);
                chk("rsp_err", rsp_err, e.err);
            end
            pop_edges.push_back(cyc + 1);
        end
    end

    // Called on a falling edge; returns on the falling edge after the request was accepted.
    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [3:0] be,
                         input logic [DW-1:0] wd, input logic er, input logic [DW-1:0] ed);
        int n = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_be = be; req_wdata = wd;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_accept_timeout", req_ready, 1);
        end else begin
            last_acc = cyc + 1;
            if (!we) exp_q.push_back({er, ed});
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic wait_init_a();
        int n = 0;
        int noisy = 0;
        while (init_busy && n < 200) begin
            if (req_ready || rsp_valid) noisy++;
            n++;
            @(negedge clk);
        end
        chk("init_len_a", n, DEP);
        chk("init_quiet_a", noisy, 0);
        chk("post_init_ready_a", req_ready, 1);
    endtask

    task automatic b_phase();
        int n = 0;
        int noisy = 0;
        while (b_init_busy && n < 200) begin
            if (b_req_ready) noisy++;
            n++;
            @(negedge clk);
        end
        chk("init_len_b", n, 16);
        chk("init_ready_low_b", noisy, 0);
        // RD_LAT=1: each read's response is visible on the very next falling edge.
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                chk("b_rsp_valid", b_rsp_valid, 1);
                chk("b_rsp_data", b_rsp_rdata, 0);
                chk("b_rsp_err", b_rsp_err, 0);
            end
            if (i < 16) begin
                chk("b_req_ready", b_req_ready, 1);
                b_req_valid = 1'b1;
                b_req_addr  = 4'(i);
            end else begin
                b_req_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("b_idle", b_rsp_valid, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int first_acc;
        int nacc;
        logic [AW-1:0] a;

        req_valid = 0; req_we = 0; req_addr = '0; req_be = '0; req_wdata = '0; rsp_ready = 1'b1;
        b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_be = '0; b_req_wdata = '0; b_rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_busy", init_busy, 1);
        rst_n = 1'b1;
        fork
            wait_init_a();
            b_phase();
        join

        // Zero-filled array reads back as zero everywhere in range.
        for (int i = 0; i < DEP; i++) issue(1'b0, AW'(i), 4'h0, '0, 1'b0, 32'h0);
        drain();

        // Byte enables, including read-after-write on the next cycle.
        issue(1'b1, 4'd5, 4'b1111, 32'hDEAD_BEEF, 1'b0, '0);
        issue(1'b1, 4'd5, 4'b0001, 32'h0000_00AA, 1'b0, '0);
        issue(1'b0, 4'd5, 4'b0000, '0, 1'b0, 32'hDEAD_BEAA);
        issue(1'b1, 4'd7, 4'b1111, 32'h1122_3344, 1'b0, '0);
        issue(1'b1, 4'd7, 4'b0110, 32'hAABB_CCDD, 1'b0, '0);
        issue(1'b0, 4'd7, 4'b0000, '0, 1'b0, 32'h11BB_CC44);
        drain();

        // Load distinct words, then 8 back-to-back reads: latency 2, one response per cycle.
        for (int i = 0; i < 8; i++) issue(1'b1, AW'(i), 4'hF, vec[i], 1'b0, '0);
        pop_edges.delete();
        first_acc = 0;
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, AW'(i), 4'h0, '0, 1'b0, vec[i]);
            if (i == 0) first_acc = last_acc;
        end
        drain();
        chk("b2b_count", pop_edges.size(), 8);
        if (pop_edges.size() == 8) begin
            chk("first_latency", pop_edges[0] - first_acc, RL);
            for (int i = 1; i < 8; i++) chk("b2b_gap", pop_edges[i] - pop_edges[i-1], 1);
        end

        // Backpressure: only RD_LAT+1 reads get in; the head response holds still.
        rsp_ready = 1'b0;
        nacc = 0;
        a = '0;
        req_valid = 1'b1; req_we = 1'b0; req_be = '0;
        for (int c = 0; c < 10; c++) begin
            req_addr = a;
            if (req_ready) begin
                exp_q.push_back({1'b0, vec[a]});
                nacc++;
                a = a + AW'(1);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("stall_accepts", nacc, RL + 1);
        for (int c = 0; c < 4; c++) begin
            chk("stall_ready", req_ready, 0);
            chk("stall_valid", rsp_valid, 1);
            chk("stall_data", rsp_rdata, vec[0]);
            chk("stall_err", rsp_err, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        drain();

        // Out-of-range: write dropped, read flagged, neighbours untouched.
        issue(1'b1, 4'd14, 4'hF, 32'hFFFF_FFFF, 1'b0, '0);
        issue(1'b0, 4'd14, 4'h0, '0, 1'b1, 32'h0);
        issue(1'b0, 4'd3,  4'h0, '0, 1'b0, vec[3]);
        issue(1'b0, 4'd6,  4'h0, '0, 1'b0, vec[6]);
        issue(1'b0, 4'd12, 4'h0, '0, 1'b1, 32'h0);
        issue(1'b0, 4'd11, 4'h0, '0, 1'b0, 32'h0);
        drain();

        // Reset with two reads in flight: they vanish and INIT reruns.
        rsp_ready = 1'b0;
        issue(1'b0, 4'd1, 4'h0, '0, 1'b0, vec[1]);
        issue(1'b0, 4'd2, 4'h0, '0, 1'b0, vec[2]);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_rdata", rsp_rdata, 0);
        chk("mid_rst_err", rsp_err, 0);
        chk("mid_rst_busy", init_busy, 1);
        repeat (2) @(negedge clk);
        rsp_ready = 1'b1;
        rst_n = 1'b1;
        wait_init_a();
        repeat (3) @(negedge clk);
        chk("post_rst_no_rsp", rsp_valid, 0);
        issue(1'b0, 4'd1, 4'h0, '0, 1'b0, 32'h0);
        issue(1'b0, 4'd12, 4'h0, '0, 1'b1, 32'h0);
        drain();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
